rom_mod_sequencer: RTL and testbench
====================================

# rom_mod_sequencer

Address sequencer and symbol scheduler for the waveform ROM (single-port, registered output, one-cycle read latency). It accepts modulation symbols over a valid/ready handshake and steps a phase accumulator once per enabled clock. It drives the ROM address and turns the ROM output into a qualified sample stream for ASK, FSK or PSK. It sits between the symbol source and the DAC/output stage of the configurable modulator.

## Interface
- `ADDR_WIDTH`, 8: ROM address width; must equal the ROM's.
- `DATA_WIDTH`, 8: ROM word width, offset-binary samples.
- `PHASE_WIDTH`, 16: accumulator width; must be at least `ADDR_WIDTH`.
- `SAMPLES_PER_SYM`, 16: ROM reads per symbol; must be at least 1.

- `clk`  in  1  single clock; ROM shares it.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  advance strobe; low freezes all state.
- `mode`  in  2  00 ASK, 01 FSK, 10 PSK, 11 treated as ASK; sampled only at symbol accept.
- `fcw0`  in  PHASE_WIDTH  phase increment for bit 0 (and for every bit in ASK/PSK).
- `fcw1`  in  PHASE_WIDTH  phase increment for bit 1 in FSK.
- `sym_valid`  in  1  symbol offered.
- `sym_data`  in  1  symbol bit.
- `sym_ready`  out  1  symbol accepted when both valid and ready are high at a rising edge.
- `rom_addr`  out  ADDR_WIDTH  registered ROM address.
- `rom_q`  in  DATA_WIDTH  ROM registered output.
- `sample_out`  out  DATA_WIDTH  registered sample.
- `sample_valid`  out  1  `sample_out` is new this cycle.
- `busy`  out  1  high when the state is RUN or pipeline samples are in flight.

## Operation
- Reset values:
  - state IDLE
  - phase 0
  - `rom_addr` 0
  - `sample_out` = 2^(DATA_WIDTH-1), i.e. midscale
  - `sample_valid` 0
  - `busy` 0
- FSM has two states, IDLE and RUN.
  - IDLE: `sym_ready` = 1. On accept, latch `mode` and `sym_data`, load the sample counter with SAMPLES_PER_SYM-1, go to RUN, and issue the first address on the same edge.
  - RUN: on each edge with `enable` high, issue one address, add the increment to the phase, and decrement the counter.
  - `sym_ready` = 1 combinationally when counter = 0 and `enable` = 1.
  - If a symbol is accepted at counter 0, stay in RUN with the new symbol. There is no bubble.
  - Otherwise go to IDLE. This is an underrun.
- Increment is `fcw1` if mode is FSK and the bit is 1, else `fcw0`. Accumulator arithmetic wraps modulo 2^PHASE_WIDTH.
- Phase is continuous across symbols. It is cleared only by reset.
- Address = phase[PHASE_WIDTH-1 -: ADDR_WIDTH], using the pre-increment phase.
- In PSK with bit 1, add 2^(ADDR_WIDTH-1) to the address, modulo 2^ADDR_WIDTH (180° offset).
- Output stage:
  - A mask flag is set for ASK with bit 0.
  - The mask flag and an issue flag are pipelined alongside the ROM latency.
  - `sample_out` = midscale when masked, else `rom_q`.
- `enable` low in RUN:
  - phase, counter, `rom_addr` and pipeline flags hold.
  - `sample_valid` is 0 on the next edge.
  - No symbol is accepted.
- `enable` does not gate acceptance in IDLE.
- `rst` asserted mid-symbol: everything returns to reset values immediately. The in-flight symbol and samples are discarded.

## Timing
- Accept/issue at edge N drives `rom_addr` after edge N. The ROM captures it at N+1. `sample_out`/`sample_valid` update at N+2.
- Address-to-sample latency is 2 edges.
- Continuous symbols at `enable` = 1 give one sample per clock, `sample_valid` held high.
- `busy` stays high until the last sample of a run has been presented.

## Configuration
- `ROM_SEQ_UNDERRUN_CNT_EN` defined:
  - adds output `underrun_cnt` [15:0], reset 0.
  - increments by 1 on each RUN→IDLE transition and saturates at 0xFFFF.
  - adds input `underrun_clr`, which is a synchronous clear with priority over increment.
- Undefined: both ports and the counter are absent. All other behaviour is identical.

## Structure
- Package `rom_seq_pkg` holds:
  - mode encodings (ASK/FSK/PSK)
  - the FSM state type
  - a midscale constant function of DATA_WIDTH
- Sub-module `rom_phase_acc` contains the accumulator register, the hold-on-disable logic and the increment select input.
- The top level holds the FSM, counter, address offset logic and output pipeline.

## Test plan
Common setup: ROM loaded with a ramp (data = address), defaults, `fcw0` = 0x0100, `fcw1` = 0x0200, `enable` = 1.

- FSK, single symbol bit 1: addresses 0,2,4…30; samples 0,2…30 starting 2 edges after accept; 16 valid pulses; then `busy` falls.
- PSK, bit 0 then bit 1 back-to-back: samples 0..15, then 144..159. There is no gap in `sample_valid` and `sym_ready` pulses at counter 0.
- ASK, bit 0: 16 valid samples all 0x80; phase still advances, so a following bit-1 symbol starts at address 16.
- Drop `enable` for 3 cycles mid-symbol: `sample_valid` is low for 3 cycles; samples resume without skipped or repeated addresses.
- Assert `rst` at sample 7: all outputs return to reset values in the same cycle. The next symbol starts at address 0.
- With `ROM_SEQ_UNDERRUN_CNT_EN` defined: three isolated symbols give `underrun_cnt` = 3. `underrun_clr` gives 0 on the next edge.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg
// Shared definitions for the waveform ROM address sequencer:
//   - modulation mode encodings as carried on the 2-bit mode input
//   - FSM state type
//   - midscale constant for offset-binary samples of a given width
//   - small decode helpers used when a symbol is issued
package rom_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ASK     = 2'b00,
    MODE_FSK     = 2'b01,
    MODE_PSK     = 2'b10,
    MODE_ASK_ALT = 2'b11   // reserved code, behaves as ASK
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Offset-binary zero level: 2^(data_width-1).
  function automatic logic [31:0] midscale(input int data_width);
    return 32'd1 << (data_width - 1);
  endfunction

  // ASK (including the reserved code) with bit 0 sends silence.
  function automatic logic mode_masks(input logic [1:0] m, input logic b);
    return ((m == MODE_ASK) || (m == MODE_ASK_ALT)) && !b;
  endfunction

  function automatic logic mode_uses_fcw1(input logic [1:0] m, input logic b);
    return (m == MODE_FSK) && b;
  endfunction

  function automatic logic mode_flips_phase(input logic [1:0] m, input logic b);
    return (m == MODE_PSK) && b;
  endfunction

endpackage

// File: rtl/rom_phase_acc.sv
// rom_phase_acc
// Phase accumulator for the ROM sequencer. Adds the selected frequency
// control word once per issued address and wraps modulo 2^PHASE_WIDTH.
// The register holds whenever advance is low, which is how enable-low
// and idle periods freeze the phase.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset (phase -> 0)
//   advance     add the increment on this edge
//   sel_fcw1    1: use fcw1, 0: use fcw0
//   fcw0, fcw1  phase increments
//   phase_msb   top ADDR_WIDTH bits of the current (pre-increment) phase
module rom_phase_acc
  import rom_seq_pkg::*;
#(
  parameter int PHASE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic                   sel_fcw1,
  input  logic [PHASE_WIDTH-1:0] fcw0,
  input  logic [PHASE_WIDTH-1:0] fcw1,
  output logic [ADDR_WIDTH-1:0]  phase_msb
);

  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] incr;

  assign incr = sel_fcw1 ? fcw1 : fcw0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (advance) begin
      phase <= phase + incr;
    end
  end

  assign phase_msb = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/rom_mod_sequencer.sv
// rom_mod_sequencer
// Address sequencer and symbol scheduler for a single-port waveform ROM
// with one-cycle registered read. Accepts one modulation symbol per
// SAMPLES_PER_SYM ROM reads, drives the ROM address from a phase
// accumulator and turns the ROM output into a qualified sample stream
// for ASK, FSK or PSK.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   enable                advance strobe; low freezes the datapath
//   mode                  00 ASK, 01 FSK, 10 PSK, 11 ASK (latched at accept)
//   fcw0, fcw1            phase increments (fcw1 only for FSK bit 1)
//   sym_valid, sym_data   symbol offer and bit
//   sym_ready             symbol accept qualifier
//   rom_addr / rom_q      ROM address out, ROM registered data in
//   sample_out            registered sample, midscale when masked
//   sample_valid          sample_out is new this cycle
//   busy                  RUN state or samples still in the pipeline
//
// Optional build macro ROM_SEQ_UNDERRUN_CNT_EN adds:
//   underrun_clr          synchronous clear of underrun_cnt
//   underrun_cnt          saturating count of RUN->IDLE transitions
//
// FSM:
//   ST_IDLE | no symbol in progress; ready to accept unconditionally
//   ST_RUN  | issuing addresses for the current symbol; counter = reads left
module rom_mod_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int PHASE_WIDTH     = 16,
  parameter int SAMPLES_PER_SYM = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [PHASE_WIDTH-1:0] fcw0,
  input  logic [PHASE_WIDTH-1:0] fcw1,
  input  logic                   sym_valid,
  input  logic                   sym_data,
  output logic                   sym_ready,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_q,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  output logic                   busy
`ifdef ROM_SEQ_UNDERRUN_CNT_EN
  ,
  input  logic                   underrun_clr,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int CNT_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(SAMPLES_PER_SYM - 1);
  localparam logic [DATA_WIDTH-1:0] MIDSCALE  = DATA_WIDTH'(midscale(DATA_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ADDR_HALF = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

  state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic             bit_q;

  logic             accept;
  logic             issue;
  logic             step;

  logic [1:0]       eff_mode;
  logic             eff_bit;
  logic             sel_fcw1;
  logic             psk_flip;
  logic             mask_now;
  logic [ADDR_WIDTH-1:0] phase_msb;

  logic             issue_d1, issue_d2;
  logic             mask_d1, mask_d2;

  // The ROM has no enable, so during a stall its output moves on to the
  // held address. The word belonging to the stage-2 flags is parked here
  // on the first stalled edge and used on the first edge after the stall.
  logic                  stalled;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] sample_src;

  // ---------------------------------------------------------------------
  // FSM next-state and handshake
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    sym_ready = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    step      = enable;
    case (state)
      ST_IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          accept    = 1'b1;
          issue     = 1'b1;
          step      = 1'b1;   // acceptance in IDLE is not gated by enable
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (enable) begin
          if (cnt == '0) begin
            sym_ready = 1'b1;
            if (sym_valid) begin
              // new symbol's first address replaces the would-be bubble
              accept = 1'b1;
              issue  = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            issue = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Symbol latch and per-symbol read counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= MODE_ASK;
      bit_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_LOAD;
      mode_q <= mode;
      bit_q  <= sym_data;
    end else if (issue) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // On the accept edge the incoming symbol already controls the issue.
  assign eff_mode = accept ? mode : mode_q;
  assign eff_bit  = accept ? sym_data : bit_q;
  assign sel_fcw1 = mode_uses_fcw1(eff_mode, eff_bit);
  assign psk_flip = mode_flips_phase(eff_mode, eff_bit);
  assign mask_now = mode_masks(eff_mode, eff_bit);

  rom_phase_acc #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_phase_acc (
    .clk       (clk),
    .rst       (rst),
    .advance   (issue),
    .sel_fcw1  (sel_fcw1),
    .fcw0      (fcw0),
    .fcw1      (fcw1),
    .phase_msb (phase_msb)
  );

  // ---------------------------------------------------------------------
  // Address register (pre-increment phase, 180 degree offset for PSK 1)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (issue) begin
      rom_addr <= phase_msb + (psk_flip ? ADDR_HALF : '0);
    end
  end

  // ---------------------------------------------------------------------
  // Output pipeline: flags travel alongside the address and ROM stages
  // ---------------------------------------------------------------------
  assign sample_src = stalled ? hold_q : rom_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_d1     <= 1'b0;
      issue_d2     <= 1'b0;
      mask_d1      <= 1'b0;
      mask_d2      <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= MIDSCALE;
      stalled      <= 1'b0;
      hold_q       <= '0;
    end else if (step) begin
      issue_d1     <= issue;
      mask_d1      <= issue & mask_now;
      issue_d2     <= issue_d1;
      mask_d2      <= mask_d1;
      sample_valid <= issue_d2;
      stalled      <= 1'b0;
      if (issue_d2) begin
        sample_out <= mask_d2 ? MIDSCALE : sample_src;
      end
    end else begin
      sample_valid <= 1'b0;
      if (!stalled) begin
        hold_q  <= rom_q;
        stalled <= 1'b1;
      end
    end
  end

  assign busy = (state == ST_RUN) | issue_d1 | issue_d2;

`ifdef ROM_SEQ_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end else if ((state == ST_RUN) && (state_nxt == ST_IDLE) &&
                 (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_mod_sequencer.sv
// tb_rom_mod_sequencer
// Directed bench for rom_mod_sequencer with a ramp ROM (data = address).
// Expected samples are generated by a small phase model when each symbol
// is offered and checked in order by a monitor whenever sample_valid is high.
// Optional build macro ROM_SEQ_UNDERRUN_CNT_EN enables the underrun counter test.
module tb_rom_mod_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] fcw0;
  logic [15:0] fcw1;
  logic        sym_valid;
  logic        sym_data;
  logic        sym_ready;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        busy;
`ifdef ROM_SEQ_UNDERRUN_CNT_EN
  logic        underrun_clr;
  logic [15:0] underrun_cnt;
`endif

  int          n_cmp;
  int          n_err;
  int          valid_cnt;
  int          rise_cnt;
  logic        prev_valid;
  logic [15:0] mphase;
  logic [7:0]  exp_q[$];
  int          w;

  rom_mod_sequencer #(
    .ADDR_WIDTH      (8),
    .DATA_WIDTH      (8),
    .PHASE_WIDTH     (16),
    .SAMPLES_PER_SYM (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .fcw0         (fcw0),
    .fcw1         (fcw1),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_ready    (sym_ready),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
`ifdef ROM_SEQ_UNDERRUN_CNT_EN
    ,
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ramp ROM, registered output
  always @(posedge clk) rom_q <= rom_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 16 samples per symbol from a 16-bit phase, ramp ROM.
  task automatic push_sym(input logic [1:0] m, input logic b);
    logic [15:0] inc;
    logic [7:0]  a;
    inc = (m == 2'b01 && b) ? fcw1 : fcw0;
    for (int k = 0; k < 16; k++) begin
      a = mphase[15:8];
      if (m == 2'b10 && b) a = a + 8'h80;
      if ((m == 2'b00 || m == 2'b11) && !b) exp_q.push_back(8'h80);
      else exp_q.push_back(a);
      mphase = mphase + inc;
    end
  endtask

  // Offer a symbol, wait (bounded) for ready, let it be accepted.
  task automatic send(input logic [1:0] m, input logic b, output int waits);
    push_sym(m, b);
    mode      = m;
    sym_data  = b;
    sym_valid = 1'b1;
    waits     = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      waits++;
      if (sym_ready) break;
    end
    check("accept_ready", {31'd0, sym_ready}, 32'd1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    mphase = 16'h0000;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    valid_cnt = 0;
    rise_cnt  = 0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        valid_cnt++;
        if (!prev_valid) rise_cnt++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed=%0h expected=none", sample_out);
        end
        if (exp_q.size() != 0) check("sample", {24'd0, sample_out}, {24'd0, exp_q.pop_front()});
      end
      prev_valid = sample_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; valid_cnt = 0; rise_cnt = 0;
    prev_valid = 1'b0; mphase = 16'h0000;
    rst = 1'b1; enable = 1'b1; mode = 2'b00;
    fcw0 = 16'h0100; fcw1 = 16'h0200;
    sym_valid = 1'b0; sym_data = 1'b0;
`ifdef ROM_SEQ_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_addr", {24'd0, rom_addr}, 32'h0);
    check("rst_sample_out", {24'd0, sample_out}, 32'h80);
    check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sym_ready", {31'd0, sym_ready}, 32'd1);
`ifdef ROM_SEQ_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
`endif
    rst = 1'b0;

    // FSK single symbol, bit 1
    send(2'b01, 1'b1, w);
    @(negedge clk);
    check("fsk_addr0", {24'd0, rom_addr}, 32'd0);
    check("fsk_valid_n1", {31'd0, sample_valid}, 32'd0);
    check("fsk_busy", {31'd0, busy}, 32'd1);
    check("fsk_ready_run", {31'd0, sym_ready}, 32'd0);
    @(negedge clk);
    check("fsk_addr1", {24'd0, rom_addr}, 32'd2);
    check("fsk_valid_n2", {31'd0, sample_valid}, 32'd0);
    @(negedge clk);
    check("fsk_valid_n3", {31'd0, sample_valid}, 32'd1);
    check("fsk_first_sample", {24'd0, sample_out}, 32'd0);
    wait_idle();
    check("fsk_count", valid_cnt, 32'd16);
    check("fsk_sb_empty", exp_q.size(), 32'd0);

    // PSK bit 0 then bit 1 back to back
    do_reset();
    send(2'b10, 1'b0, w);
    send(2'b10, 1'b1, w);
    check("psk_ready_wait", w, 32'd16);
    wait_idle();
    check("psk_count", valid_cnt, 32'd32);
    check("psk_no_gap", rise_cnt, 32'd1);
    check("psk_sb_empty", exp_q.size(), 32'd0);

    // ASK bit 0 (masked), then bit 1 continues the phase, then code 11 bit 0
    do_reset();
    send(2'b00, 1'b0, w);
    wait_idle();
    check("ask0_count", valid_cnt, 32'd16);
    send(2'b00, 1'b1, w);
    check("ask1_start_addr", {24'd0, rom_addr}, 32'd16);
    send(2'b11, 1'b0, w);
    wait_idle();
    check("ask_count", valid_cnt, 32'd48);
    check("ask_runs", rise_cnt, 32'd2);
    check("ask_sb_empty", exp_q.size(), 32'd0);

    // enable low for 3 cycles mid-symbol
    do_reset();
    send(2'b01, 1'b0, w);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, sample_valid}, 32'd0);
      check("stall_addr", {24'd0, rom_addr}, 32'd5);
    end
    enable = 1'b1;
    wait_idle();
    check("stall_count", valid_cnt, 32'd16);
    check("stall_runs", rise_cnt, 32'd2);
    check("stall_sb_empty", exp_q.size(), 32'd0);

    // reset mid-symbol
    do_reset();
    send(2'b01, 1'b0, w);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (valid_cnt >= 7) break;
    end
    check("mid_rst_reached", valid_cnt, 32'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_rom_addr", {24'd0, rom_addr}, 32'h0);
    check("mid_rst_sample_out", {24'd0, sample_out}, 32'h80);
    check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, sym_ready}, 32'd1);
    exp_q.delete();
    mphase = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_cnt = 0;
    rise_cnt  = 0;
    send(2'b01, 1'b1, w);
    check("post_rst_addr", {24'd0, rom_addr}, 32'd0);
    wait_idle();
    check("post_rst_count", valid_cnt, 32'd16);
    check("post_rst_sb_empty", exp_q.size(), 32'd0);

`ifdef ROM_SEQ_UNDERRUN_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(2'b00, 1'b1, w);
      wait_idle();
    end
    check("underrun_cnt3", {16'd0, underrun_cnt}, 32'd3);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1;
    underrun_clr = 1'b0;
    check("underrun_clr", {16'd0, underrun_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
